// File: rtl/mc_bank_sched.sv
// mc_bank_sched: PRECHARGE/ACTIVATE sequencer for one SDRAM chip select.
// Opens the requested bank/row through the open-bank tracker while honouring
// tRP, tRCD and tRAS, and closes every bank ahead of a refresh.
// Optional close-page policy: define MC_BANK_SCHED_CLOSE_PAGE_EN to precharge
// the bank after every grant; undefined keeps banks open (open-page policy).
module mc_bank_sched #(
   parameter int unsigned TRP  = 3,
   parameter int unsigned TRCD = 3,
   parameter int unsigned TRAS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [1:0]  req_bank,
   input  logic [12:0] req_row,
   output logic        ack,
   input  logic        rfr_req,
   output logic        rfr_ack,
   output logic [1:0]  bank_adr,
   output logic [12:0] row_adr,
   output logic        bank_set,
   output logic        bank_clr,
   output logic        bank_clr_all,
   input  logic        bank_open,
   input  logic        row_same,
   input  logic        any_bank_open,
   output logic        cmd_valid,
   output logic [1:0]  cmd
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_PRE,
      S_WAIT_RP,
      S_ACT,
      S_WAIT_RCD,
      S_GRANT,
      S_PREALL,
      S_WAIT_RPA,
      S_RFR_DONE
   } state_t;

   localparam logic [1:0] CMD_ACT  = 2'd0;
   localparam logic [1:0] CMD_PRE  = 2'd1;
   localparam logic [1:0] CMD_PREA = 2'd2;

   // Wait timers hold N-1 in the command cycle so the wait state exits on zero.
   localparam logic [3:0] TRP_M1  = 4'(TRP - 1);
   localparam logic [3:0] TRCD_M1 = 4'(TRCD - 1);
   localparam logic [3:0] TRAS_M1 = 4'(TRAS - 1);

   state_t      state_q;
   logic [3:0]  timer_q, timer_d;
   logic [3:0]  tras_q, tras_d;
   logic        tras_ok;
   logic        ack_q, rfr_ack_q;
   logic        bank_set_q, bank_clr_q, bank_clr_all_q;
   logic        cmd_valid_q;
   logic [1:0]  cmd_q;
   logic [1:0]  bank_adr_q;
   logic [12:0] row_adr_q;
`ifdef MC_BANK_SCHED_CLOSE_PAGE_EN
   logic        close_q;
`endif

   assign ack          = ack_q;
   assign rfr_ack      = rfr_ack_q;
   assign bank_set     = bank_set_q;
   assign bank_clr     = bank_clr_q;
   assign bank_clr_all = bank_clr_all_q;
   assign cmd_valid    = cmd_valid_q;
   assign cmd          = cmd_q;
   assign bank_adr     = bank_adr_q;
   assign row_adr      = row_adr_q;

   // Saturating timer/tRAS next values; tras_ok looks one cycle ahead so a
   // registered PRE/PREA strobe lands exactly in the first cycle tRAS is met.
   always_comb begin
      timer_d = (timer_q != '0) ? timer_q - 4'd1 : '0;
      tras_d  = (tras_q != '0) ? tras_q - 4'd1 : '0;
      if (state_q == S_ACT) begin
         tras_d = TRAS_M1;
      end
      tras_ok = (tras_d == '0);
   end

   // Scheduler FSM with registered command strobes and handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         timer_q        <= '0;
         tras_q         <= '0;
         ack_q          <= 1'b0;
         rfr_ack_q      <= 1'b0;
         bank_set_q     <= 1'b0;
         bank_clr_q     <= 1'b0;
         bank_clr_all_q <= 1'b0;
         cmd_valid_q    <= 1'b0;
         cmd_q          <= CMD_ACT;
         bank_adr_q     <= '0;
         row_adr_q      <= '0;
`ifdef MC_BANK_SCHED_CLOSE_PAGE_EN
         close_q        <= 1'b0;
`endif
      end else begin
         ack_q          <= 1'b0;
         rfr_ack_q      <= 1'b0;
         bank_set_q     <= 1'b0;
         bank_clr_q     <= 1'b0;
         bank_clr_all_q <= 1'b0;
         cmd_valid_q    <= 1'b0;
         timer_q        <= timer_d;
         tras_q         <= tras_d;

         unique case (state_q)
            S_IDLE: begin
               if (rfr_req) begin
                  if (any_bank_open) begin
                     state_q <= S_PREALL;
                     if (tras_ok) begin
                        bank_clr_all_q <= 1'b1;
                        cmd_valid_q    <= 1'b1;
                        cmd_q          <= CMD_PREA;
                        timer_q        <= TRP_M1;
                     end
                  end else begin
                     state_q   <= S_RFR_DONE;
                     rfr_ack_q <= 1'b1;
                  end
               end else if (req) begin
                  bank_adr_q <= req_bank;
                  row_adr_q  <= req_row;
                  state_q    <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (bank_open && row_same) begin
                  state_q <= S_GRANT;
                  ack_q   <= 1'b1;
               end else if (bank_open) begin
                  state_q <= S_PRE;
                  if (tras_ok) begin
                     bank_clr_q  <= 1'b1;
                     cmd_valid_q <= 1'b1;
                     cmd_q       <= CMD_PRE;
                     timer_q     <= TRP_M1;
                  end
               end else begin
                  state_q     <= S_ACT;
                  bank_set_q  <= 1'b1;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= CMD_ACT;
                  timer_q     <= TRCD_M1;
               end
            end

            // bank_clr_q high means the PRE strobe is being driven this cycle.
            S_PRE: begin
               if (bank_clr_q) begin
                  state_q <= S_WAIT_RP;
               end else if (tras_ok) begin
                  bank_clr_q  <= 1'b1;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= CMD_PRE;
                  timer_q     <= TRP_M1;
               end
            end

            S_WAIT_RP: begin
               if (timer_q == '0) begin
`ifdef MC_BANK_SCHED_CLOSE_PAGE_EN
                  if (close_q) begin
                     state_q <= S_IDLE;
                     close_q <= 1'b0;
                  end else begin
                     state_q     <= S_ACT;
                     bank_set_q  <= 1'b1;
                     cmd_valid_q <= 1'b1;
                     cmd_q       <= CMD_ACT;
                     timer_q     <= TRCD_M1;
                  end
`else
                  state_q     <= S_ACT;
                  bank_set_q  <= 1'b1;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= CMD_ACT;
                  timer_q     <= TRCD_M1;
`endif
               end
            end

            S_ACT: begin
               state_q <= S_WAIT_RCD;
            end

            S_WAIT_RCD: begin
               if (timer_q == '0) begin
                  state_q <= S_GRANT;
                  ack_q   <= 1'b1;
               end
            end

            S_GRANT: begin
`ifdef MC_BANK_SCHED_CLOSE_PAGE_EN
               state_q <= S_PRE;
               close_q <= 1'b1;
               if (tras_ok) begin
                  bank_clr_q  <= 1'b1;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= CMD_PRE;
                  timer_q     <= TRP_M1;
               end
`else
               state_q <= S_IDLE;
`endif
            end

            // bank_clr_all_q high means the PREA strobe is being driven this cycle.
            S_PREALL: begin
               if (bank_clr_all_q) begin
                  state_q <= S_WAIT_RPA;
               end else if (tras_ok) begin
                  bank_clr_all_q <= 1'b1;
                  cmd_valid_q    <= 1'b1;
                  cmd_q          <= CMD_PREA;
                  timer_q        <= TRP_M1;
               end
            end

            S_WAIT_RPA: begin
               if (timer_q == '0) begin
                  state_q   <= S_RFR_DONE;
                  rfr_ack_q <= 1'b1;
               end
            end

            S_RFR_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mc_bank_sched.sv
// tb_mc_bank_sched: scoreboard bench for mc_bank_sched with a behavioural
// open-bank tracker and a cycle-level timing model of the scheduler rules.
module tb_mc_bank_sched;

   localparam int P_TRP  = 3;
   localparam int P_TRCD = 3;
   localparam int P_TRAS = 8;

   // Event kinds: 0..3 follow the cmd encoding, then the two handshakes.
   localparam int K_ACT  = 0;
   localparam int K_PRE  = 1;
   localparam int K_PREA = 2;
   localparam int K_ACK  = 5;
   localparam int K_RACK = 6;

   typedef struct {
      int          kind;
      int          cyc;
      logic [1:0]  bank;
      logic [12:0] row;
   } ev_t;

   ev_t expq[$];

   logic        clk = 1'b0;
   logic        rst, req, rfr_req;
   logic [1:0]  req_bank;
   logic [12:0] req_row;
   logic        ack, rfr_ack, bank_set, bank_clr, bank_clr_all, cmd_valid;
   logic [1:0]  bank_adr, cmd;
   logic [12:0] row_adr;
   logic        bank_open, row_same, any_bank_open;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Reference model state
   int          last_act = -1000;
   int          next_idle = 0;
   bit [3:0]    mopen = '0;
   logic [12:0] mrow[4];

   // Behavioural tracker driven by the DUT strobes
   logic [3:0]  trk_open;
   logic [12:0] trk_row[4];
   logic        trk_clr;

   mc_bank_sched #(
      .TRP (P_TRP),
      .TRCD(P_TRCD),
      .TRAS(P_TRAS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_bank     (req_bank),
      .req_row      (req_row),
      .ack          (ack),
      .rfr_req      (rfr_req),
      .rfr_ack      (rfr_ack),
      .bank_adr     (bank_adr),
      .row_adr      (row_adr),
      .bank_set     (bank_set),
      .bank_clr     (bank_clr),
      .bank_clr_all (bank_clr_all),
      .bank_open    (bank_open),
      .row_same     (row_same),
      .any_bank_open(any_bank_open),
      .cmd_valid    (cmd_valid),
      .cmd          (cmd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (trk_clr) begin
         trk_open <= '0;
         for (int i = 0; i < 4; i++) trk_row[i] <= '0;
      end else begin
         if (bank_set) begin
            trk_open[bank_adr] <= 1'b1;
            trk_row[bank_adr]  <= row_adr;
         end
         if (bank_clr) trk_open[bank_adr] <= 1'b0;
         if (bank_clr_all) trk_open <= '0;
      end
   end

   assign bank_open     = trk_open[bank_adr];
   assign row_same      = (trk_row[bank_adr] == row_adr);
   assign any_bank_open = |trk_open;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic void push(input int k, input int c, input logic [1:0] b, input logic [12:0] r);
      ev_t e;
      e.kind = k;
      e.cyc  = c;
      e.bank = b;
      e.row  = r;
      expq.push_back(e);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every visible strobe/handshake is matched against the scoreboard.
   always @(negedge clk) begin : monitor
      int  n_pulse;
      int  n_ev;
      int  k;
      ev_t e;
      if (mon_en) begin
         n_pulse = int'(bank_set) + int'(bank_clr) + int'(bank_clr_all);
         if (cmd_valid || n_pulse != 0) begin
            checks++;
            if (!(cmd_valid && n_pulse == 1 &&
                  ((cmd == 2'd0 && bank_set) || (cmd == 2'd1 && bank_clr) ||
                   (cmd == 2'd2 && bank_clr_all)))) begin
               errors++;
               $display("FAIL cmd_strobe: cycle %0d cmd_valid=%b cmd=%0d set=%b clr=%b clr_all=%b, required exactly one strobe matching cmd",
                        cyc, cmd_valid, cmd, bank_set, bank_clr, bank_clr_all);
            end
         end
         n_ev = int'(cmd_valid) + int'(ack) + int'(rfr_ack);
         if (n_ev > 1) begin
            checks++;
            errors++;
            $display("FAIL event_overlap: cycle %0d cmd_valid=%b ack=%b rfr_ack=%b, required at most one", cyc, cmd_valid, ack, rfr_ack);
         end
         if (n_ev != 0) begin
            k = cmd_valid ? int'(cmd) : (ack ? K_ACK : K_RACK);
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", k, cyc);
            end else begin
               e = expq.pop_front();
               if (k != e.kind || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL event_kind_cycle: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d", k, cyc, e.kind, e.cyc);
               end
               if (e.kind == K_ACT || e.kind == K_PRE) begin
                  checks++;
                  if (bank_adr != e.bank || (e.kind == K_ACT && row_adr != e.row)) begin
                     errors++;
                     $display("FAIL cmd_address: cycle %0d got bank=%0d row=0x%0h, required bank=%0d row=0x%0h",
                              cyc, bank_adr, row_adr, e.bank, (e.kind == K_ACT) ? e.row : row_adr);
                  end
               end
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({ack, rfr_ack, bank_set, bank_clr, bank_clr_all, cmd_valid} !== 6'b0) begin
         errors++;
         $display("FAIL %s_pulses: got ack=%b rfr_ack=%b set=%b clr=%b clr_all=%b cmd_valid=%b, required all 0",
                  tag, ack, rfr_ack, bank_set, bank_clr, bank_clr_all, cmd_valid);
      end
      checks++;
      if (cmd !== 2'd0) begin
         errors++;
         $display("FAIL %s_cmd: got %0d, required 0", tag, cmd);
      end
      checks++;
      if (bank_adr !== 2'd0) begin
         errors++;
         $display("FAIL %s_bank_adr: got %0d, required 0", tag, bank_adr);
      end
      checks++;
      if (row_adr !== 13'd0) begin
         errors++;
         $display("FAIL %s_row_adr: got 0x%0h, required 0", tag, row_adr);
      end
   endtask

   // One operation from an idle scheduler: optional refresh, then optional request.
   task automatic do_op(input bit r, input logic [1:0] b, input logic [12:0] rw, input bit f, input int gap);
      int t, p, a, g, n;
      bit sa, sf, dr, df;
      next_idle += gap;
      while (cyc < next_idle) next_cycle();
      t = cyc;
      if (f) begin
         if (mopen != 4'b0) begin
            p = imax(t + 1, last_act + P_TRAS);
            push(K_PREA, p, 2'd0, 13'd0);
            mopen = '0;
            t = p + P_TRP;
         end else begin
            t = t + 1;
         end
         push(K_RACK, t, 2'd0, 13'd0);
         t = t + 1;
      end
      if (r) begin
         if (mopen[b] && mrow[b] == rw) begin
            g = t + 2;
         end else begin
            a = t + 2;
            if (mopen[b]) begin
               p = imax(t + 2, last_act + P_TRAS);
               push(K_PRE, p, b, 13'd0);
               a = p + P_TRP;
            end
            push(K_ACT, a, b, rw);
            last_act = a;
            mopen[b] = 1'b1;
            mrow[b]  = rw;
            g = a + P_TRCD;
         end
         push(K_ACK, g, b, rw);
         t = g + 1;
`ifdef MC_BANK_SCHED_CLOSE_PAGE_EN
         p = imax(g + 1, last_act + P_TRAS);
         push(K_PRE, p, b, 13'd0);
         mopen[b] = 1'b0;
         t = p + P_TRP;
`endif
      end
      next_idle = t;

      req_bank = b;
      req_row  = rw;
      req      = r;
      rfr_req  = f;
      dr = !r;
      df = !f;
      n  = 0;
      while (!(dr && df) && n < 100) begin
         @(negedge clk);
         sa = ack;
         sf = rfr_ack;
         next_cycle();
         if (sa && !dr) begin
            req = 1'b0;
            dr  = 1'b1;
         end
         if (sf && !df) begin
            rfr_req = 1'b0;
            df      = 1'b1;
         end
         n++;
      end
      checks++;
      if (!(dr && df)) begin
         errors++;
         $display("FAIL handshake_timeout: cycle %0d ack_seen=%b rfr_ack_seen=%b, required both seen within 100 cycles", cyc, dr, df);
         req     = 1'b0;
         rfr_req = 1'b0;
      end
   endtask

   // Miss request on a closed bank, aborted by reset during the tRCD wait.
   task automatic reset_test(input logic [1:0] b, input logic [12:0] rw);
      int c0;
      while (cyc < next_idle) next_cycle();
      c0 = cyc;
      push(K_ACT, c0 + 2, b, rw);
      mopen[b] = 1'b1;
      mrow[b]  = rw;
      req_bank = b;
      req_row  = rw;
      req      = 1'b1;
      next_cycle();
      next_cycle();
      next_cycle();
      rst = 1'b1;
      req = 1'b0;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midop_reset");
      last_act  = -1000;
      next_idle = c0 + 8;
   endtask

   initial begin : stimulus
      logic [1:0]  b;
      logic [12:0] rw;
      int          kind;
      rst      = 1'b1;
      req      = 1'b0;
      rfr_req  = 1'b0;
      req_bank = '0;
      req_row  = '0;
      trk_clr  = 1'b1;
      for (int i = 0; i < 4; i++) mrow[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      trk_clr = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      next_cycle();
      rst       = 1'b0;
      next_idle = cyc;
      mon_en    = 1'b1;

      // Directed: miss, conflict right after ACT (tRAS stall), hit, refreshes
      do_op(1'b1, 2'd1, 13'h0123, 1'b0, 0);
      do_op(1'b1, 2'd1, 13'h0456, 1'b0, 0);
      do_op(1'b1, 2'd1, 13'h0456, 1'b0, 0);
      do_op(1'b0, 2'd0, 13'h0000, 1'b1, 0);
      do_op(1'b0, 2'd0, 13'h0000, 1'b1, 2);
      do_op(1'b1, 2'd2, 13'h0abc, 1'b1, 1);
      do_op(1'b0, 2'd0, 13'h0000, 1'b1, 0);
      reset_test(2'd3, 13'h1f0f);

      // Randomised mix of requests, refreshes and simultaneous arrivals
      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 9));
         b    = 2'($urandom_range(0, 3));
         if (mopen[b] && $urandom_range(0, 1) == 1) rw = mrow[b];
         else rw = 13'($urandom_range(0, 8191));
         do_op(kind >= 2, b, rw, kind <= 2, int'($urandom_range(0, 2)));
      end

      while (cyc < next_idle + 5) next_cycle();
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d unobserved, required 0 (first kind=%0d cycle=%0d)",
                  expq.size(), expq[0].kind, expq[0].cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
